// File: rtl/squeeze_ctrl_pkg.sv
// Shared types and width helpers for the squeeze/expand sequencer and the layer-chaining top.
// Widths follow max(1, clog2(n)) so single-entry counters still get one bit.
package squeeze_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_EMIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int calc_aw(input int chin);
      return clog2_min1(chin);
   endfunction

   function automatic int calc_pw(input int w_in);
      return clog2_min1(w_in * w_in);
   endfunction

   function automatic int calc_gw(input int chout, input int dsp_no);
      return clog2_min1(chout / dsp_no);
   endfunction

endpackage

// File: rtl/en_delay.sv
// Fixed-depth delay line turning ifm accepts into MAC enables DEPTH cycles later.
// Async clear drops every in-flight pulse; there is no stall input.
module en_delay #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] sr_q;
   logic [DEPTH-1:0] sr_d;

   always_comb begin
      sr_d = (sr_q << 1) | DEPTH'(din);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/squeeze_ctrl.sv
// Sequencer for the 1x1 conv MAC array: walks channels, pixels and output groups, strobes results.
// Pixel period at full rate is CHIN+PIPE+1 cycles; ifm stalls only delay the channel walk.
module squeeze_ctrl
   import squeeze_ctrl_pkg::*;
#(
   parameter int CHIN   = 128,
   parameter int CHOUT  = 16,
   parameter int DSP_NO = 16,
   parameter int W_IN   = 16,
   parameter int PIPE   = 2,
   localparam int AW    = calc_aw(CHIN),
   localparam int PW    = calc_pw(W_IN),
   localparam int GW    = calc_gw(CHOUT, DSP_NO)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          ifm_valid,
   output logic          ifm_ready,
   output logic [AW-1:0] weight_addr,
   output logic [GW-1:0] grp_idx,
   output logic          mac_en,
   output logic          mac_clr,
   output logic          ofm_valid,
   output logic [PW-1:0] pix_idx,
   output logic          busy,
   output logic          layer_end
);

   localparam int NPIX = W_IN * W_IN;
   localparam int NGRP = CHOUT / DSP_NO;
   localparam int DW   = clog2_min1(PIPE);

   state_e        state_q, state_d;
   logic [AW-1:0] ch_q, ch_d;
   logic [PW-1:0] pix_q, pix_d;
   logic [GW-1:0] grp_q, grp_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic          first_q, first_d;
   logic          accept;

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      pix_d   = pix_q;
      grp_d   = grp_q;
      dcnt_d  = dcnt_q;
      first_d = 1'b0;
      accept  = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               ch_d    = '0;
               pix_d   = '0;
               grp_d   = '0;
               first_d = 1'b1;
            end
         end
         ST_RUN: begin
            accept = ifm_valid;
            if (ifm_valid) begin
               if (ch_q == AW'(CHIN - 1)) begin
                  ch_d    = '0;
                  dcnt_d  = '0;
                  state_d = ST_DRAIN;
               end else begin
                  ch_d = ch_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (dcnt_q == DW'(PIPE - 1)) begin
               state_d = ST_EMIT;
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
         ST_EMIT: begin
            // The last pixel of the last group leaves pix/grp untouched so DONE shows them.
            if (pix_q == PW'(NPIX - 1)) begin
               if (grp_q == GW'(NGRP - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  pix_d   = '0;
                  grp_d   = grp_q + 1'b1;
                  state_d = ST_RUN;
               end
            end else begin
               pix_d   = pix_q + 1'b1;
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ch_q    <= '0;
         pix_q   <= '0;
         grp_q   <= '0;
         dcnt_q  <= '0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         pix_q   <= pix_d;
         grp_q   <= grp_d;
         dcnt_q  <= dcnt_d;
         first_q <= first_d;
      end
   end

   en_delay #(.DEPTH(PIPE)) u_en_delay (
      .clk   (clk),
      .rst_n (rst),
      .din   (accept),
      .dout  (mac_en)
   );

   assign ifm_ready   = (state_q == ST_RUN);
   assign ofm_valid   = (state_q == ST_EMIT);
   assign mac_clr     = first_q | (state_q == ST_EMIT);
   assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_EMIT);
   assign layer_end   = (state_q == ST_DONE);
   assign weight_addr = ch_q;
   assign pix_idx     = pix_q;
   assign grp_idx     = grp_q;

endmodule

// File: doc/squeeze_ctrl.md
# squeeze_ctrl

Sequencer for the 1x1 squeeze/expand convolution datapath: DSP_NO MACs that share one streamed ifm pixel per cycle and one ROM-fed kernel word per MAC. It generates the weight ROM address, the MAC enable and clear, and a single-cycle output-sample strobe. It also walks pixels and output-channel groups and flags layer end. It replaces derived sampling clocks with single-clock strobes, and sits between the layer-chaining logic (start/layer_end) and the MAC array.

## Interface
- CHIN, 128, input channels accumulated per output pixel
- CHOUT, 16, output channels; must be an integer multiple of DSP_NO
- DSP_NO, 16, MACs in the array (one output channel each per group)
- W_IN, 16, feature-map side; NPIX = W_IN*W_IN pixels
- PIPE, 2, cycles from ifm accept to that beat's accumulation (ROM + kernel register)
- Derived: NGRP = CHOUT/DSP_NO; AW = max(1,$clog2(CHIN)); PW = max(1,$clog2(NPIX)); GW = max(1,$clog2(NGRP))

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  level sampled in IDLE or DONE; begins a layer pass
- ifm_valid  in  1  ifm beat present this cycle
- ifm_ready  out  1  controller accepts a beat; accept = ifm_valid & ifm_ready
- weight_addr  out  AW  ROM address = current channel index ch
- grp_idx  out  GW  current output-channel group (ROM bank select)
- mac_en  out  1  accumulate enable, accept delayed exactly PIPE cycles
- mac_clr  out  1  synchronous accumulator clear
- ofm_valid  out  1  one-cycle strobe: MAC outputs (+bias, ReLU) are final, sample now
- pix_idx  out  PW  pixel index of the result strobed by ofm_valid
- busy  out  1  high in RUN, DRAIN, EMIT
- layer_end  out  1  high in DONE

## Operation
- States: IDLE, RUN, DRAIN, EMIT, DONE.
- IDLE: start=1 -> RUN; ch, pix, grp cleared. Outputs: ifm_ready=0, mac_en=0, mac_clr=0.
- RUN: ifm_ready=1. mac_clr=1 in the first RUN cycle after start.
- Each accept increments ch. An accept with ch==CHIN-1 wraps ch to 0 and goes to DRAIN. No accept: ch and weight_addr hold.
- DRAIN: ifm_ready=0 for exactly PIPE cycles -> EMIT.
- EMIT: one cycle. ofm_valid=1 and mac_clr=1, pix_idx=pix. Then pix increments.
- Wrap rule: pix==NPIX-1 wraps pix to 0 and increments grp. If that pixel was also in grp NGRP-1 -> DONE, else -> RUN.
- Loop order: grp outer, pix inner.
- DONE: layer_end=1, grp_idx/pix_idx hold final values. start=1 -> RUN with counters cleared (same as IDLE exit), layer_end drops.
- mac_en is a PIPE-deep delay of accept. It is never high in the same cycle as mac_clr (guaranteed by DRAIN length).
- start while busy is ignored. ifm_valid outside RUN is ignored.
- Reset mid-pass: all state and delay line cleared immediately, IDLE. In-flight mac_en pulses are discarded.

## Timing
- Reset values: ifm_ready=0, weight_addr=0, grp_idx=0, mac_en=0, mac_clr=0, ofm_valid=0, pix_idx=0, busy=0, layer_end=0.
- All outputs are registered or decoded from registered state; no combinational path from ifm_valid or start to any output.
- The last accept of a pixel at cycle t gives mac_en at t+PIPE and ofm_valid at t+PIPE+1. RUN resumes at t+PIPE+2.
- Full-rate pixel period = CHIN+PIPE+1 cycles (131 at defaults).
- Start sampled at cycle s: RUN and mac_clr at s+1, first accept possible at s+1.
- layer_end rises the cycle after the final EMIT.

## Structure
- Package squeeze_ctrl_pkg holds the state enum and the width-helper functions (AW/PW/GW computation). It is shared with the layer-chaining top.
- Sub-module en_delay: a PIPE-deep shift register with async active-low clear. It produces mac_en from accept.
- Counters and FSM stay in squeeze_ctrl.

## Test plan
- Reset: hold rst=0 with random inputs -> all outputs at reset values. Release: outputs stay in reset values until start.
- Full rate (CHIN=4, W_IN=2, PIPE=2, CHOUT=DSP_NO=16), start at cycle 0, ifm_valid=1:
  - mac_clr at cycle 1, accepts at cycles 1-4, mac_en at cycles 3-6.
  - ofm_valid at 7, 14, 21, 28 with pix_idx 0,1,2,3.
  - layer_end=1 from cycle 29.
- Bubbles: same params, ifm_valid toggling 1,0 -> exactly 4 accepts per pixel, weight_addr holds through gaps, mac_en count=16, ofm_valid count=4.
- Groups: CHOUT=32, DSP_NO=16 -> 8 ofm_valid strobes. grp_idx=0 for pix 0-3, then grp_idx=1 for pix 0-3, then layer_end.
- Robustness: start pulsed mid-RUN -> no effect on counters. rst pulsed during DRAIN -> immediate reset values, no ofm_valid after release until a new start.
- Restart: start in DONE -> layer_end=0 next cycle, mac_clr=1, full pass repeats with identical strobe timing.
